// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared constants and types for the selection arbiter
package vend_pkg;
  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic [1:0] {IDLE, OFFER, WAIT} vend_arb_state_t;
  typedef logic [CODE_W-1:0] vend_code_t;
endpackage

// File: rtl/vend_select_arbiter_if.sv
// rtl/vend_select_arbiter_if.sv - button/dispenser handshake bundle for the arbiter
interface vend_select_arbiter_if;
  import vend_pkg::*;

  logic             enable;
  logic [N_REQ-1:0] req;
  logic             dsp_ready;
  logic             dsp_done;
  logic             clr_err;
  logic             sel_valid;
  vend_code_t       sel_code;
  logic             busy;
  logic             timeout_err;
  logic [N_REQ-1:0] pending;

  modport master (
    output enable, req, dsp_ready, dsp_done, clr_err,
    input  sel_valid, sel_code, busy, timeout_err, pending
  );

  modport slave (
    input  enable, req, dsp_ready, dsp_done, clr_err,
    output sel_valid, sel_code, busy, timeout_err, pending
  );
endinterface

// File: rtl/vend_req_picker.sv
// rtl/vend_req_picker.sv - picks the next code from pending; VEND_ROUND_ROBIN_EN selects round-robin
module vend_req_picker
  import vend_pkg::*;
(
  input  logic [N_REQ-1:0] i_pending,
  input  vend_code_t       i_last_grant,
  output vend_code_t       o_code
);

`ifdef VEND_ROUND_ROBIN_EN
  // Walk from the farthest candidate to the nearest so the nearest hit below last_grant wins.
  always_comb begin
    o_code = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_pending[i_last_grant - vend_code_t'(k)]) o_code = i_last_grant - vend_code_t'(k);
    end
  end
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = ^i_last_grant;

  always_comb begin
    o_code = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i_pending[i]) o_code = vend_code_t'(i);
    end
  end
`endif

endmodule

// File: rtl/vend_select_arbiter.sv
// rtl/vend_select_arbiter.sv - captures button presses, grants one code at a time, tracks dispense timeout
module vend_select_arbiter
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input logic                 clk,
  input logic                 rst,
  vend_select_arbiter_if.slave bus
);

  vend_arb_state_t  r_state;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] r_req_q;
  logic             r_sel_valid;
  vend_code_t       r_sel_code;
  vend_code_t       r_last_grant;
  logic             r_busy;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [N_REQ-1:0] w_rise;
  logic [N_REQ-1:0] w_clr_mask;
  logic             w_accept;
  logic             w_timeout;
  vend_code_t       w_pick;

  assign w_rise     = bus.req & ~r_req_q & {N_REQ{bus.enable}};
  assign w_accept   = r_sel_valid & bus.dsp_ready;
  assign w_clr_mask = w_accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << r_sel_code) : '0;
  // done in the deadline cycle beats the timeout
  assign w_timeout  = (r_state == WAIT) && !bus.dsp_done &&
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  vend_req_picker u_picker (
    .i_pending    (r_pending),
    .i_last_grant (r_last_grant),
    .o_code       (w_pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pending    <= '0;
      r_req_q      <= '0;
      r_sel_valid  <= 1'b0;
      r_sel_code   <= '0;
      r_last_grant <= '0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_req_q   <= bus.req;
      r_pending <= (r_pending & ~w_clr_mask) | w_rise;
      r_err     <= (r_err & ~bus.clr_err) | w_timeout;
      case (r_state)
        IDLE: begin
          if (bus.enable && |r_pending) begin
            r_sel_code  <= w_pick;
            r_sel_valid <= 1'b1;
            r_state     <= OFFER;
          end
        end
        OFFER: begin
          if (w_accept) begin
            r_sel_valid  <= 1'b0;
            r_busy       <= 1'b1;
            r_cnt        <= '0;
            r_last_grant <= r_sel_code;
            r_state      <= WAIT;
          end else if (!bus.enable) begin
            r_sel_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        WAIT: begin
          if (bus.dsp_done || w_timeout) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sel_valid   = r_sel_valid;
  assign bus.sel_code    = r_sel_code;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_err;
  assign bus.pending     = r_pending;

endmodule

// File: tb/tb_vend_select_arbiter.sv
// tb/tb_vend_select_arbiter.sv - directed, table and random checks of vend_select_arbiter against a reference model
module tb_vend_select_arbiter;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   chk_on = 1'b0;

  vend_select_arbiter_if bus ();

  vend_select_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         phase;  // 0 idle, 1 offering, 2 waiting for dispenser
    logic [7:0] pend;
    logic [7:0] req_q;
    logic       valid;
    logic       busy;
    logic       err;
    logic [2:0] code;
    logic [2:0] lg;
    int         cnt;
  } mstate_t;

  mstate_t m = '0;

  function automatic logic [2:0] ref_pick(logic [7:0] p, logic [2:0] lg);
`ifdef VEND_ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      int idx = (int'(lg) - k + 8) % 8;
      if (p[idx]) return 3'(idx);
    end
`else
    for (int i = 7; i >= 0; i--) if (p[i]) return 3'(i);
`endif
    return 3'd0;
  endfunction

  function automatic mstate_t model_next(mstate_t s, logic r, logic en, logic [7:0] rq,
                                         logic rdy, logic dn, logic clr);
    mstate_t n = s;
    logic acc;
    logic to;
    if (r) return '0;
    acc = s.valid && rdy;
    to = 1'b0;
    n.req_q = rq;
    if (acc) n.pend[s.code] = 1'b0;
    n.pend = n.pend | (rq & ~s.req_q & {8{en}});
    case (s.phase)
      0: if (en && s.pend != 0) begin
        n.code = ref_pick(s.pend, s.lg); n.valid = 1'b1; n.phase = 1;
      end
      1: if (acc) begin
        n.valid = 1'b0; n.busy = 1'b1; n.cnt = 0; n.lg = s.code; n.phase = 2;
      end else if (!en) begin
        n.valid = 1'b0; n.phase = 0;
      end
      default: if (dn) begin
        n.busy = 1'b0; n.phase = 0;
      end else if (s.cnt == T - 1) begin
        to = 1'b1; n.busy = 1'b0; n.phase = 0;
      end else begin
        n.cnt = s.cnt + 1;
      end
    endcase
    n.err = to ? 1'b1 : (clr ? 1'b0 : s.err);
    return n;
  endfunction

  always @(posedge clk)
    m <= model_next(m, rst, bus.enable, bus.req, bus.dsp_ready, bus.dsp_done, bus.clr_err);

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if ({bus.sel_valid, bus.sel_code, bus.busy, bus.timeout_err, bus.pending} !==
          {m.valid, m.code, m.busy, m.err, m.pend}) begin
        failures++;
        $display("FAIL model_cmp t=%0t valid=%b/%b code=%0d/%0d busy=%b/%b err=%b/%b pend=%h/%h (actual/required)",
                 $time, bus.sel_valid, m.valid, bus.sel_code, m.code, bus.busy, m.busy,
                 bus.timeout_err, m.err, bus.pending, m.pend);
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(logic [7:0] mask);
    bus.req = mask;
    tick();
    bus.req = '0;
  endtask

  task automatic pulse_done();
    bus.dsp_done = 1'b1;
    tick();
    bus.dsp_done = 1'b0;
  endtask

  task automatic wait_valid(string name, logic [2:0] code);
    int n = 0;
    while (!bus.sel_valid && n < 8) begin
      tick();
      n++;
    end
    chk({name, "_valid"}, int'(bus.sel_valid), 1);
    chk({name, "_code"}, int'(bus.sel_code), int'(code));
  endtask

  typedef struct {
    logic [7:0] req;
    logic [2:0] code;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h01, 3'd0};
    vecs[1] = '{8'h80, 3'd7};
    vecs[2] = '{8'h81, 3'd7};
    vecs[3] = '{8'h3C, 3'd5};
    vecs[4] = '{8'h12, 3'd4};
    vecs[5] = '{8'h7E, 3'd6};
    vecs[6] = '{8'h02, 3'd1};
    vecs[7] = '{8'h55, 3'd6};

    bus.enable = 1'b0; bus.req = 8'hFF; bus.dsp_ready = 1'b0;
    bus.dsp_done = 1'b0; bus.clr_err = 1'b0;

    // reset with all buttons held
    rst = 1'b1;
    repeat (3) tick();
    chk_on = 1'b1;
    chk("rst_valid", int'(bus.sel_valid), 0);
    chk("rst_code", int'(bus.sel_code), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_err", int'(bus.timeout_err), 0);
    chk("rst_pending", int'(bus.pending), 0);
    rst = 1'b0; bus.req = '0;
    tick();

    // single request latency
    bus.enable = 1'b1; bus.dsp_ready = 1'b1;
    press(8'h20);
    chk("single_pending", int'(bus.pending), 32'h20);
    chk("single_early_valid", int'(bus.sel_valid), 0);
    tick();
    chk("single_valid", int'(bus.sel_valid), 1);
    chk("single_code", int'(bus.sel_code), 5);
    tick();
    chk("single_busy", int'(bus.busy), 1);
    chk("single_cleared", int'(bus.pending), 0);
    pulse_done();
    chk("single_done", int'(bus.busy), 0);

    // simultaneous presses
    press(8'h44);
    wait_valid("prio_first", 3'd6);
    tick();
    chk("prio_left", int'(bus.pending), 32'h04);
    pulse_done();
    wait_valid("prio_second", 3'd2);
    tick();
    pulse_done();

    // backpressure and withdraw
    bus.dsp_ready = 1'b0;
    press(8'h08);
    wait_valid("bp", 3'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", int'(bus.sel_valid), 1);
      chk("bp_hold_code", int'(bus.sel_code), 3);
    end
    bus.enable = 1'b0;
    tick();
    chk("withdraw_valid", int'(bus.sel_valid), 0);
    chk("withdraw_pending", int'(bus.pending), 32'h08);
    bus.enable = 1'b1;
    wait_valid("reoffer", 3'd3);
    bus.dsp_ready = 1'b1;
    tick();
    pulse_done();

    // timeout, clear, and done on the deadline cycle
    press(8'h02);
    wait_valid("to", 3'd1);
    tick();
    chk("to_busy0", int'(bus.busy), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_busy", int'(bus.busy), 1);
      chk("to_noerr", int'(bus.timeout_err), 0);
    end
    tick();
    chk("to_busy_drop", int'(bus.busy), 0);
    chk("to_err", int'(bus.timeout_err), 1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("to_clr", int'(bus.timeout_err), 0);
    press(8'h01);
    wait_valid("late_done", 3'd0);
    tick();
    repeat (3) tick();
    pulse_done();
    chk("late_done_busy", int'(bus.busy), 0);
    chk("late_done_err", int'(bus.timeout_err), 0);

    // reset while waiting with requests pending
    press(8'h0F);
    wait_valid("midrst", 3'd3);
    tick();
    chk("midrst_busy", int'(bus.busy), 1);
    chk("midrst_pend", int'(bus.pending), 32'h07);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_pending", int'(bus.pending), 0);
    chk("midrst_idle", int'(bus.busy), 0);
    chk("midrst_valid", int'(bus.sel_valid), 0);
    tick();
    chk("midrst_nogrant", int'(bus.sel_valid), 0);

    // first-grant table from a clean reset
    for (int v = 0; v < 8; v++) begin
      rst = 1'b1; tick(); rst = 1'b0;
      bus.dsp_ready = 1'b0; bus.enable = 1'b1;
      press(vecs[v].req);
      chk("tbl_pending", int'(bus.pending), int'(vecs[v].req));
      wait_valid("tbl", vecs[v].code);
    end
    rst = 1'b1; tick(); rst = 1'b0;

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.req       = 8'($urandom & $urandom & $urandom);
      bus.enable    = ($urandom_range(0, 9) != 0);
      bus.dsp_ready = ($urandom_range(0, 1) != 0);
      bus.dsp_done  = ($urandom_range(0, 4) == 0);
      bus.clr_err   = ($urandom_range(0, 19) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
